// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding and the
// saved-PC register select encodings used by the control decoder.
package definitions;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_e;

  localparam logic [1:0] kPC_NONE = 2'd0;
  localparam logic [1:0] kPC_R1   = 2'd1;
  localparam logic [1:0] kPC_R2   = 2'd2;
  localparam logic [1:0] kPC_R3   = 2'd3;

endpackage

// File: rtl/pc_save_regs.sv
// Three saved-PC registers with one write port and one combinational read
// port. Select 00 addresses no register: writes are dropped, reads return 0.
module pc_save_regs
  import definitions::*;
#(
  parameter int PC_W = 10
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wr_en_i,
  input  logic [1:0]      wr_sel_i,
  input  logic [PC_W-1:0] wr_data_i,
  input  logic [1:0]      rd_sel_i,
  output logic [PC_W-1:0] rd_data_o
);

  logic [3:1][PC_W-1:0] regs_w;

  for (genvar gi = 1; gi <= 3; gi++) begin : g_reg
    logic [PC_W-1:0] val_q;

    // Each register loads only when its own select code is written.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        val_q <= '0;
      end else if (wr_en_i && (wr_sel_i == 2'(gi))) begin
        val_q <= wr_data_i;
      end
    end

    assign regs_w[gi] = val_q;
  end

  // Read mux; returns the pre-write value when read and write coincide.
  always_comb begin
    rd_data_o = '0;
    case (rd_sel_i)
      kPC_R1:  rd_data_o = regs_w[1];
      kPC_R2:  rd_data_o = regs_w[2];
      kPC_R3:  rd_data_o = regs_w[3];
      default: rd_data_o = '0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Program counter and run/halt sequencing for the instruction ROM.
// Optional feature: define FETCH_BRANCH_CNT_EN to add a saturating
// 16-bit count of taken branches on output BranchCount.
module fetch_unit
  import definitions::*;
#(
  parameter int PC_W       = 10,
  parameter int SPC_OFFSET = 2
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Ack,
  input  logic            JumpEqual,
  input  logic            JumpNotEqual,
  input  logic            OffsetEn,
  input  logic [1:0]      PCRegSelect,
  input  logic            SaveEn,
  input  logic            EqualFlag,
  output logic [PC_W-1:0] ProgCtr,
  output logic            Running,
  output logic            Done,
`ifdef FETCH_BRANCH_CNT_EN
  output logic [15:0]     BranchCount,
`endif
  output logic            BranchTaken
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] save_data;
  logic [PC_W-1:0] jump_target;
  logic            is_run;
  logic            sel_valid;
  logic            taken;
  logic            save_en;

  assign is_run    = (state_q == RUN);
  assign sel_valid = (PCRegSelect != kPC_NONE);
  assign taken     = (JumpEqual & EqualFlag) | (JumpNotEqual & ~EqualFlag);
  assign save_en   = is_run & SaveEn & sel_valid & ~Ack;
  // Return address is the next instruction, optionally skipped ahead.
  assign save_data = pc_q + PC_W'(1) + (OffsetEn ? PC_W'(SPC_OFFSET) : '0);

  assign BranchTaken = is_run & taken & sel_valid;
  assign ProgCtr     = pc_q;
  assign Running     = is_run;
  assign Done        = (state_q == DONE);

  pc_save_regs #(
    .PC_W(PC_W)
  ) u_pc_save_regs (
    .clk_i    (Clk),
    .rst_i    (Reset),
    .wr_en_i  (save_en),
    .wr_sel_i (PCRegSelect),
    .wr_data_i(save_data),
    .rd_sel_i (PCRegSelect),
    .rd_data_o(jump_target)
  );

  // State and program counter registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next state and next PC; Ack has priority over jumps in RUN.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: begin
        pc_d = '0;
        if (Start) state_d = RUN;
      end
      RUN: begin
        if (Ack) begin
          state_d = DONE;
        end else if (taken && sel_valid) begin
          pc_d = jump_target;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      DONE: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
  end

`ifdef FETCH_BRANCH_CNT_EN
  logic [15:0] bcnt_q;
  logic        start_accept;

  assign start_accept = Start & ((state_q == IDLE) | (state_q == DONE));
  assign BranchCount  = bcnt_q;

  // Saturating taken-branch counter, cleared whenever a new run starts.
  always_ff @(posedge Clk) begin
    if (Reset || start_accept) begin
      bcnt_q <= '0;
    end else if (BranchTaken && (bcnt_q != 16'hFFFF)) begin
      bcnt_q <= bcnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with hand-computed expected PCs.
module tb_fetch_unit;

  localparam int PC_W = 10;

  logic            Clk = 1'b0;
  logic            Reset;
  logic            Start;
  logic            Ack;
  logic            JumpEqual;
  logic            JumpNotEqual;
  logic            OffsetEn;
  logic [1:0]      PCRegSelect;
  logic            SaveEn;
  logic            EqualFlag;
  logic [PC_W-1:0] ProgCtr;
  logic            Running;
  logic            Done;
  logic            BranchTaken;
`ifdef FETCH_BRANCH_CNT_EN
  logic [15:0]     BranchCount;
`endif

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit #(
    .PC_W      (PC_W),
    .SPC_OFFSET(2)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .Ack         (Ack),
    .JumpEqual   (JumpEqual),
    .JumpNotEqual(JumpNotEqual),
    .OffsetEn    (OffsetEn),
    .PCRegSelect (PCRegSelect),
    .SaveEn      (SaveEn),
    .EqualFlag   (EqualFlag),
    .ProgCtr     (ProgCtr),
    .Running     (Running),
    .Done        (Done),
`ifdef FETCH_BRANCH_CNT_EN
    .BranchCount (BranchCount),
`endif
    .BranchTaken (BranchTaken)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end else begin
      $display("ok   %s: %0d", tag, act);
    end
  endtask

  task automatic set_ctl(input logic je, input logic jne, input logic off,
                         input logic [1:0] sel, input logic save, input logic eq);
    JumpEqual    = je;
    JumpNotEqual = jne;
    OffsetEn     = off;
    PCRegSelect  = sel;
    SaveEn       = save;
    EqualFlag    = eq;
  endtask

  task automatic clr_ctl();
    set_ctl(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input int exp);
`ifdef FETCH_BRANCH_CNT_EN
    check(tag, 32'(BranchCount), 32'(exp));
`endif
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    Ack   = 1'b0;
    clr_ctl();
    tick();
    tick();
    Reset = 1'b0;
    check("rst_pc", 32'(ProgCtr), 0);
    check("rst_running", 32'(Running), 0);
    check("rst_done", 32'(Done), 0);
    check_cnt("rst_cnt", 0);

    tick();
    check("idle_pc", 32'(ProgCtr), 0);
    check("idle_running", 32'(Running), 0);

    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("start_running", 32'(Running), 1);
    check("start_pc", 32'(ProgCtr), 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("seq_pc", 32'(ProgCtr), 32'(i));
    end

    // PC=3: save to PCreg2 with offset -> 3+1+2 = 6
    set_ctl(1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0);
    tick();
    clr_ctl();
    check("save2_pc", 32'(ProgCtr), 4);
    tick();
    // PC=5: save to PCreg1 without offset -> 6
    set_ctl(1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
    tick();
    clr_ctl();
    check("save1_pc", 32'(ProgCtr), 6);
    for (int i = 0; i < 3; i++) tick();
    check("pc9", 32'(ProgCtr), 9);

    // jne, flag 0, sel 1 -> taken to 6
    set_ctl(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    #1 check("jne_bt", 32'(BranchTaken), 1);
    tick();
    clr_ctl();
    check("jne_pc", 32'(ProgCtr), 6);

    // je, flag 0 -> not taken
    set_ctl(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
    #1 check("je_nt_bt", 32'(BranchTaken), 0);
    tick();
    check("je_nt_pc", 32'(ProgCtr), 7);

    // je with select 00 -> no-op even though condition holds
    set_ctl(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    #1 check("je_sel0_bt", 32'(BranchTaken), 0);
    tick();
    check("je_sel0_pc", 32'(ProgCtr), 8);

    // je, flag 1, sel 2 -> taken to 6
    set_ctl(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1);
    #1 check("je_t_bt", 32'(BranchTaken), 1);
    tick();
    check("je_t_pc", 32'(ProgCtr), 6);

    // save PCreg1 <- 6+1+2 = 9 and jump through PCreg1 same cycle -> old value 6
    set_ctl(1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0);
    tick();
    check("savejump_pc", 32'(ProgCtr), 6);
    set_ctl(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    tick();
    check("newreg1_pc", 32'(ProgCtr), 9);

    // both je and jne high, flag 1 -> taken to PCreg2 = 6
    set_ctl(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1);
    #1 check("both_bt", 32'(BranchTaken), 1);
    tick();
    clr_ctl();
    check("both_pc", 32'(ProgCtr), 6);
    for (int i = 0; i < 6; i++) tick();
    check("pc12", 32'(ProgCtr), 12);

    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    check("ack_done", 32'(Done), 1);
    check("ack_running", 32'(Running), 0);
    check("ack_pc", 32'(ProgCtr), 12);
    check_cnt("done_cnt", 5);
    tick();
    check("done_hold_pc", 32'(ProgCtr), 12);

    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("restart_pc", 32'(ProgCtr), 0);
    check("restart_running", 32'(Running), 1);
    check("restart_done", 32'(Done), 0);
    check_cnt("restart_cnt", 0);

    // PCreg1 kept its value 9 across DONE
    set_ctl(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    tick();
    clr_ctl();
    check("keep_reg1_pc", 32'(ProgCtr), 9);
    for (int i = 0; i < 1013; i++) tick();
    check("pc1022", 32'(ProgCtr), 1022);
    tick();
    check("pc1023", 32'(ProgCtr), 1023);

    // PC=1023: save PCreg3 with offset -> (1024+2) mod 1024 = 2; PC wraps to 0
    set_ctl(1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0);
    tick();
    clr_ctl();
    check("wrap_pc", 32'(ProgCtr), 0);
    set_ctl(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
    tick();
    clr_ctl();
    check("reg3_wrap_pc", 32'(ProgCtr), 2);
    check_cnt("run2_cnt", 2);

    // Start ignored while running
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("start_in_run_pc", 32'(ProgCtr), 3);

    // Reset mid-run
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("midrst_pc", 32'(ProgCtr), 0);
    check("midrst_running", 32'(Running), 0);
    check("midrst_done", 32'(Done), 0);
    check_cnt("midrst_cnt", 0);

    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    check("post_rst_pc", 32'(ProgCtr), 1);
    // All saved registers cleared: taken jumps land on 0
    set_ctl(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    #1 check("clr_reg1_bt", 32'(BranchTaken), 1);
    tick();
    check("clr_reg1_pc", 32'(ProgCtr), 0);
    set_ctl(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
    tick();
    clr_ctl();
    check("clr_reg3_pc", 32'(ProgCtr), 0);
    tick();
    check("after_clr_pc", 32'(ProgCtr), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and fetch-sequencing stage that drives the instruction ROM address and consumes the control decoder's jump/save outputs. Holds three saved-PC registers (written by `spc`, read by `je`/`jne`), the start/done handshake with the testbench, and the run/halt state machine. Sits directly upstream of the instruction ROM → control decoder path, closing the loop from decoder and ALU flag back to the next ROM address.

## Interface
- `PC_W`, default 10: program counter / instruction ROM address width.
- `SPC_OFFSET`, default 2: extra displacement added to a saved PC when `OffsetEn` = 1.
- `Clk` input 1: system clock, all state updates on rising edge.
- `Reset` input 1: synchronous, active-high; one clock, reset is synchronous and active-high.
- `Start` input 1: begin program execution from address 0.
- `Ack` input 1: decoder "done with program" (all-ones instruction).
- `JumpEqual` input 1: current instruction is `je`.
- `JumpNotEqual` input 1: current instruction is `jne`.
- `OffsetEn` input 1: `spc` saves with `SPC_OFFSET` added.
- `PCRegSelect` input 2: saved-PC register select; 00 = none, 01/10/11 = PCreg1/2/3.
- `SaveEn` input 1: current instruction is `spc`.
- `EqualFlag` input 1: ALU equal flag for the current instruction.
- `ProgCtr` output PC_W: registered instruction ROM address.
- `Running` output 1: high while in RUN.
- `Done` output 1: high while in DONE.
- `BranchTaken` output 1: combinational; current cycle's jump is taken.

## Operation
- States: IDLE, RUN, DONE (encoded as a package enum).
- IDLE: `ProgCtr` held at 0; `Start` = 1 → RUN on next edge, `ProgCtr` stays 0 (first instruction is address 0).
- RUN, per cycle, in priority order:
  - `Ack` = 1 → DONE; `ProgCtr` holds; no save, no jump.
  - taken = (`JumpEqual` & `EqualFlag`) | (`JumpNotEqual` & ~`EqualFlag`), and `PCRegSelect` ≠ 00 → `ProgCtr` ← PCreg[`PCRegSelect`].
  - otherwise `ProgCtr` ← `ProgCtr` + 1, mod 2^PC_W (PC = 2^PC_W−1 wraps to 0).
- `BranchTaken` = RUN & taken & (`PCRegSelect` ≠ 00).
- Save: RUN & `SaveEn` & `PCRegSelect` ≠ 00 & ~`Ack` → PCreg[sel] ← `ProgCtr` + 1 + (`OffsetEn` ? `SPC_OFFSET` : 0), truncated to PC_W bits.
- Save and jump in the same cycle: both act; the jump target is the pre-write register value.
- Jump with `PCRegSelect` = 00 is a no-op: PC increments, `BranchTaken` = 0.
- `JumpEqual` and `JumpNotEqual` both high: taken if either term is true.
- DONE: `ProgCtr` and PCregs hold; `Start` = 1 → RUN with `ProgCtr` ← 0; PCregs keep their values.
- `Start` is ignored in RUN.

## Timing
- Reset, including mid-RUN: state IDLE, `ProgCtr` = 0, PCreg1..3 = 0, `Running` = 0, `Done` = 0, branch counter = 0.
- `ProgCtr` changes one cycle after the deciding inputs. ROM, decoder and ALU flag resolve combinationally in the same cycle, so every instruction including jumps has a 1-cycle latency.
- `Running` and `Done` are decoded from the registered state. `Done` rises the cycle after `Ack`.

## Configuration
- `FETCH_BRANCH_CNT_EN` defined: adds output `BranchCount` [15:0].
  - Counts cycles with `BranchTaken` = 1.
  - Saturates at 16'hFFFF.
  - Cleared by `Reset` and by `Start` accepted in IDLE or DONE.
- Undefined: no port and no counter logic.

## Structure
- Package `definitions`:
  - fetch state enum (IDLE/RUN/DONE).
  - PCRegSelect encodings (`kPC_NONE`, `kPC_R1`..`kPC_R3`).
- Sub-module `pc_save_regs`: 3 × PC_W register file.
  - One write port: sel, data, enable.
  - One combinational read port: sel. Reading sel = 00 returns 0.

## Test plan
- Reset, then `Start` pulse → `ProgCtr` sequence 0,1,2,3 on successive cycles, `Running` = 1.
- At PC = 5: `SaveEn`, sel = 01, `OffsetEn` = 0 → PCreg1 = 6. At PC = 9: `JumpNotEqual`, sel = 01, `EqualFlag` = 0 → next PC = 6, `BranchTaken` = 1.
- At PC = 3: `SaveEn`, sel = 10, `OffsetEn` = 1 → PCreg2 = 6. Later `JumpEqual`, sel = 10, `EqualFlag` = 0 → not taken, PC increments.
- PC = 1023 with no jump → next PC = 0. Save at PC = 1023 with offset → PCreg = (1024 + 2) mod 1024 = 2.
- `Ack` at PC = 12 → `Done` = 1 next cycle, PC holds at 12. `Start` → PC = 0, RUN. `Reset` mid-RUN → IDLE, PC = 0, PCregs = 0.
- With `FETCH_BRANCH_CNT_EN`: 3 taken jumps and 1 not-taken jump → `BranchCount` = 3; `Start` from DONE → 0.
